// File: rtl/rs_cdb_wakeup.sv
// rs_cdb_wakeup: reservation station that snoops N CDB lanes and issues one op per cycle.
// Optional RS_WAKE_ISSUE_EN: a same-cycle CDB hit completes readiness for select.
module rs_cdb_wakeup #(
  parameter int DEPTH  = 8,
  parameter int N      = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int PAY_W  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [N-1:0]                 disp_valid,
  input  logic [N*PAY_W-1:0]           disp_payload,
  input  logic [N*TAG_W-1:0]           disp_dest_tag,
  input  logic [N*TAG_W-1:0]           disp_src1_tag,
  input  logic [N*TAG_W-1:0]           disp_src2_tag,
  input  logic [N-1:0]                 disp_src1_rdy,
  input  logic [N-1:0]                 disp_src2_rdy,
  input  logic [N*DATA_W-1:0]          disp_src1_val,
  input  logic [N*DATA_W-1:0]          disp_src2_val,
  output logic [$clog2(DEPTH+1)-1:0]   free_slots,
  input  logic [N-1:0]                 cdb_valid,
  input  logic [N*TAG_W-1:0]           cdb_tag,
  input  logic [N*DATA_W-1:0]          cdb_data,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [PAY_W-1:0]             iss_payload,
  output logic [TAG_W-1:0]             iss_dest_tag,
  output logic [DATA_W-1:0]            iss_src1_val,
  output logic [DATA_W-1:0]            iss_src2_val
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PAY_W-1:0]  pay;
    logic [TAG_W-1:0]  dst;
    logic [TAG_W-1:0]  t1;
    logic              r1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  t2;
    logic              r2;
    logic [DATA_W-1:0] v2;
  } ent_t;

  ent_t              ent_q [DEPTH];
  ent_t              ent_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CW-1:0]     free_q, free_d;
  logic [CW-1:0]     cnt;

  logic [DEPTH-1:0]  w1_hit, w2_hit;
  logic [DATA_W-1:0] w1_val [DEPTH];
  logic [DATA_W-1:0] w2_val [DEPTH];
  logic [DEPTH-1:0]  rdy1, rdy2;
  logic [DATA_W-1:0] op1 [DEPTH];
  logic [DATA_W-1:0] op2 [DEPTH];

  logic              sel_v;
  logic [IW-1:0]     sel;
  logic              fire;

  logic [DEPTH-1:0]  taken;
  logic              found;
  logic [N-1:0]      alloc_v;
  logic [IW-1:0]     alloc_idx [N];

  function automatic logic lane_hit(
    input logic [N-1:0]       v,
    input logic [N*TAG_W-1:0] tg,
    input logic [TAG_W-1:0]   t
  );
    lane_hit = 1'b0;
    for (int l = 0; l < N; l++)
      if (v[l] && tg[l*TAG_W +: TAG_W] == t) lane_hit = 1'b1;
  endfunction

  // Scan high to low so the lowest matching lane wins.
  function automatic logic [DATA_W-1:0] lane_val(
    input logic [N-1:0]        v,
    input logic [N*TAG_W-1:0]  tg,
    input logic [N*DATA_W-1:0] dt,
    input logic [TAG_W-1:0]    t
  );
    lane_val = '0;
    for (int l = N-1; l >= 0; l--)
      if (v[l] && tg[l*TAG_W +: TAG_W] == t)
        lane_val = dt[l*DATA_W +: DATA_W];
  endfunction

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w1_hit[e] = lane_hit(cdb_valid, cdb_tag, ent_q[e].t1);
      w2_hit[e] = lane_hit(cdb_valid, cdb_tag, ent_q[e].t2);
      w1_val[e] = lane_val(cdb_valid, cdb_tag, cdb_data, ent_q[e].t1);
      w2_val[e] = lane_val(cdb_valid, cdb_tag, cdb_data, ent_q[e].t2);
`ifdef RS_WAKE_ISSUE_EN
      rdy1[e] = ent_q[e].r1 | w1_hit[e];
      rdy2[e] = ent_q[e].r2 | w2_hit[e];
      op1[e]  = ent_q[e].r1 ? ent_q[e].v1 : w1_val[e];
      op2[e]  = ent_q[e].r2 ? ent_q[e].v2 : w2_val[e];
`else
      rdy1[e] = ent_q[e].r1;
      rdy2[e] = ent_q[e].r2;
      op1[e]  = ent_q[e].v1;
      op2[e]  = ent_q[e].v2;
`endif
    end
  end

  always_comb begin
    sel_v = 1'b0;
    sel   = '0;
    for (int e = DEPTH-1; e >= 0; e--) begin
      if (busy_q[e] && rdy1[e] && rdy2[e]) begin
        sel_v = 1'b1;
        sel   = IW'(e);
      end
    end
  end

  assign fire         = sel_v & iss_ready;
  assign iss_valid    = sel_v;
  assign iss_payload  = sel_v ? ent_q[sel].pay : '0;
  assign iss_dest_tag = sel_v ? ent_q[sel].dst : '0;
  assign iss_src1_val = sel_v ? op1[sel] : '0;
  assign iss_src2_val = sel_v ? op2[sel] : '0;
  assign free_slots   = free_q;

  // Only entries free at the start of the cycle are allocatable.
  always_comb begin
    taken   = '0;
    found   = 1'b0;
    alloc_v = '0;
    for (int s = 0; s < N; s++) begin
      alloc_idx[s] = '0;
      found        = 1'b0;
      if (disp_valid[s]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (!found && !busy_q[e] && !taken[e]) begin
            found        = 1'b1;
            taken[e]     = 1'b1;
            alloc_idx[s] = IW'(e);
            alloc_v[s]   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int e = 0; e < DEPTH; e++) begin
      ent_d[e] = ent_q[e];
      if (busy_q[e] && !ent_q[e].r1 && w1_hit[e]) begin
        ent_d[e].r1 = 1'b1;
        ent_d[e].v1 = w1_val[e];
      end
      if (busy_q[e] && !ent_q[e].r2 && w2_hit[e]) begin
        ent_d[e].r2 = 1'b1;
        ent_d[e].v2 = w2_val[e];
      end
    end
    if (fire) busy_d[sel] = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (alloc_v[s]) begin
        busy_d[alloc_idx[s]] = 1'b1;
        ent_d[alloc_idx[s]].pay = disp_payload[s*PAY_W +: PAY_W];
        ent_d[alloc_idx[s]].dst = disp_dest_tag[s*TAG_W +: TAG_W];
        ent_d[alloc_idx[s]].t1  = disp_src1_tag[s*TAG_W +: TAG_W];
        ent_d[alloc_idx[s]].t2  = disp_src2_tag[s*TAG_W +: TAG_W];
        ent_d[alloc_idx[s]].r1  = disp_src1_rdy[s] |
          lane_hit(cdb_valid, cdb_tag, disp_src1_tag[s*TAG_W +: TAG_W]);
        ent_d[alloc_idx[s]].r2  = disp_src2_rdy[s] |
          lane_hit(cdb_valid, cdb_tag, disp_src2_tag[s*TAG_W +: TAG_W]);
        ent_d[alloc_idx[s]].v1  = disp_src1_rdy[s] ?
          disp_src1_val[s*DATA_W +: DATA_W] :
          lane_val(cdb_valid, cdb_tag, cdb_data, disp_src1_tag[s*TAG_W +: TAG_W]);
        ent_d[alloc_idx[s]].v2  = disp_src2_rdy[s] ?
          disp_src2_val[s*DATA_W +: DATA_W] :
          lane_val(cdb_valid, cdb_tag, cdb_data, disp_src2_tag[s*TAG_W +: TAG_W]);
      end
    end
    if (flush) busy_d = '0;
    cnt = '0;
    for (int e = 0; e < DEPTH; e++) cnt = cnt + CW'(busy_d[e]);
    free_d = CW'(DEPTH) - cnt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      free_q <= CW'(DEPTH);
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
    end else begin
      busy_q <= busy_d;
      free_q <= free_d;
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= ent_d[e];
    end
  end

endmodule

// File: tb/tb_rs_cdb_wakeup.sv
// tb_rs_cdb_wakeup: vector table, directed corner sequences and random traffic
// checked against an entry-list model of the reservation station.
module tb_rs_cdb_wakeup;
  localparam int D = 8, N = 2, TW = 6, DW = 32, PW = 16, CW = 4;

  logic clock = 1'b0;
  logic reset, flush, iss_ready, iss_valid;
  logic [N-1:0] disp_valid, disp_src1_rdy, disp_src2_rdy, cdb_valid;
  logic [N*PW-1:0] disp_payload;
  logic [N*TW-1:0] disp_dest_tag, disp_src1_tag, disp_src2_tag, cdb_tag;
  logic [N*DW-1:0] disp_src1_val, disp_src2_val, cdb_data;
  logic [CW-1:0] free_slots;
  logic [PW-1:0] iss_payload;
  logic [TW-1:0] iss_dest_tag;
  logic [DW-1:0] iss_src1_val, iss_src2_val;

  always #5 clock = ~clock;

  rs_cdb_wakeup dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_dest_tag(disp_dest_tag), .disp_src1_tag(disp_src1_tag),
    .disp_src2_tag(disp_src2_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_rdy(disp_src2_rdy), .disp_src1_val(disp_src1_val),
    .disp_src2_val(disp_src2_val), .free_slots(free_slots),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_payload(iss_payload), .iss_dest_tag(iss_dest_tag),
    .iss_src1_val(iss_src1_val), .iss_src2_val(iss_src2_val)
  );

  int checks = 0, fails = 0;

  logic          m_busy [D];
  logic [PW-1:0] m_pay  [D];
  logic [TW-1:0] m_dst  [D], m_t1 [D], m_t2 [D];
  logic          m_r1   [D], m_r2 [D];
  logic [DW-1:0] m_v1   [D], m_v2 [D];
  int            m_free;

  logic          e_v;
  int            e_idx;
  logic [PW-1:0] e_pay;
  logic [TW-1:0] e_dst;
  logic [DW-1:0] e_v1, e_v2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < D; e++) begin
      m_busy[e] = 0; m_r1[e] = 0; m_r2[e] = 0;
    end
    m_free = D;
  endtask

  task automatic cdb_look(input logic [TW-1:0] t, output logic hit, output logic [DW-1:0] val);
    hit = 0; val = 0;
    for (int l = 0; l < N; l++)
      if (!hit && cdb_valid[l] && cdb_tag[l*TW +: TW] == t) begin
        hit = 1; val = cdb_data[l*DW +: DW];
      end
  endtask

  task automatic model_eval();
    logic ok1, ok2;
    logic [DW-1:0] a1, a2;
`ifdef RS_WAKE_ISSUE_EN
    logic h;
    logic [DW-1:0] v;
`endif
    e_v = 0; e_idx = 0; e_pay = 0; e_dst = 0; e_v1 = 0; e_v2 = 0;
    for (int e = 0; e < D; e++) begin
      ok1 = m_r1[e]; a1 = m_v1[e];
      ok2 = m_r2[e]; a2 = m_v2[e];
`ifdef RS_WAKE_ISSUE_EN
      if (!ok1) begin cdb_look(m_t1[e], h, v); if (h) begin ok1 = 1; a1 = v; end end
      if (!ok2) begin cdb_look(m_t2[e], h, v); if (h) begin ok2 = 1; a2 = v; end end
`endif
      if (!e_v && m_busy[e] && ok1 && ok2) begin
        e_v = 1; e_idx = e; e_pay = m_pay[e]; e_dst = m_dst[e];
        e_v1 = a1; e_v2 = a2;
      end
    end
  endtask

  task automatic model_check();
    model_eval();
    chk("iss_valid", 64'(iss_valid), 64'(e_v));
    if (e_v) begin
      chk("iss_payload", 64'(iss_payload), 64'(e_pay));
      chk("iss_dest_tag", 64'(iss_dest_tag), 64'(e_dst));
      chk("iss_src1_val", 64'(iss_src1_val), 64'(e_v1));
      chk("iss_src2_val", 64'(iss_src2_val), 64'(e_v2));
    end
    chk("free_slots", 64'(free_slots), 64'(m_free));
  endtask

  task automatic advance();
    logic ob [D];
    logic tk [D];
    logic h, fire;
    logic [DW-1:0] v;
    int f;
    model_eval();
    fire = e_v && iss_ready;
    for (int e = 0; e < D; e++) begin ob[e] = m_busy[e]; tk[e] = 0; end
    if (flush) begin
      for (int e = 0; e < D; e++) m_busy[e] = 0;
    end else begin
      for (int e = 0; e < D; e++) if (m_busy[e]) begin
        if (!m_r1[e]) begin cdb_look(m_t1[e], h, v); if (h) begin m_r1[e] = 1; m_v1[e] = v; end end
        if (!m_r2[e]) begin cdb_look(m_t2[e], h, v); if (h) begin m_r2[e] = 1; m_v2[e] = v; end end
      end
      if (fire) m_busy[e_idx] = 0;
      for (int s = 0; s < N; s++) if (disp_valid[s]) begin
        f = -1;
        for (int e = 0; e < D; e++) if (f < 0 && !ob[e] && !tk[e]) f = e;
        if (f >= 0) begin
          tk[f] = 1; m_busy[f] = 1;
          m_pay[f] = disp_payload[s*PW +: PW];
          m_dst[f] = disp_dest_tag[s*TW +: TW];
          m_t1[f] = disp_src1_tag[s*TW +: TW];
          m_t2[f] = disp_src2_tag[s*TW +: TW];
          m_r1[f] = disp_src1_rdy[s]; m_v1[f] = disp_src1_val[s*DW +: DW];
          m_r2[f] = disp_src2_rdy[s]; m_v2[f] = disp_src2_val[s*DW +: DW];
          if (!m_r1[f]) begin cdb_look(m_t1[f], h, v); if (h) begin m_r1[f] = 1; m_v1[f] = v; end end
          if (!m_r2[f]) begin cdb_look(m_t2[f], h, v); if (h) begin m_r2[f] = 1; m_v2[f] = v; end end
        end
      end
    end
    m_free = 0;
    for (int e = 0; e < D; e++) if (!m_busy[e]) m_free++;
    @(posedge clock);
    #1;
  endtask

  task automatic pre();
    #1;
    model_check();
  endtask

  task automatic cyc();
    pre();
    advance();
  endtask

  task automatic idle();
    flush = 0; iss_ready = 0; disp_valid = 0; cdb_valid = 0;
    disp_payload = 0; disp_dest_tag = 0; disp_src1_tag = 0; disp_src2_tag = 0;
    disp_src1_rdy = 0; disp_src2_rdy = 0; disp_src1_val = 0; disp_src2_val = 0;
    cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic set_slot(input int s, input logic [PW-1:0] pay, input logic [TW-1:0] dst,
                          input logic [TW-1:0] t1, input logic r1, input logic [DW-1:0] v1,
                          input logic [TW-1:0] t2, input logic r2, input logic [DW-1:0] v2);
    disp_valid[s] = 1;
    disp_payload[s*PW +: PW] = pay;
    disp_dest_tag[s*TW +: TW] = dst;
    disp_src1_tag[s*TW +: TW] = t1; disp_src1_rdy[s] = r1; disp_src1_val[s*DW +: DW] = v1;
    disp_src2_tag[s*TW +: TW] = t2; disp_src2_rdy[s] = r2; disp_src2_val[s*DW +: DW] = v2;
  endtask

  task automatic set_lane(input int l, input logic [TW-1:0] t, input logic [DW-1:0] d);
    cdb_valid[l] = 1;
    cdb_tag[l*TW +: TW] = t;
    cdb_data[l*DW +: DW] = d;
  endtask

  typedef struct {
    logic dv; logic [PW-1:0] pay; logic [TW-1:0] dst, t1; logic r1; logic [DW-1:0] v1;
    logic [TW-1:0] t2; logic r2; logic [DW-1:0] v2;
    logic cv; int lane; logic [TW-1:0] ct; logic [DW-1:0] cd; logic irdy;
    logic ev; logic [TW-1:0] edst; logic [DW-1:0] ev1, ev2; int efree;
  } vec_t;

  function automatic vec_t mk(
    logic dv, logic [PW-1:0] pay, logic [TW-1:0] dst, logic [TW-1:0] t1, logic r1,
    logic [DW-1:0] v1, logic [TW-1:0] t2, logic r2, logic [DW-1:0] v2,
    logic cv, int lane, logic [TW-1:0] ct, logic [DW-1:0] cd, logic irdy,
    logic ev, logic [TW-1:0] edst, logic [DW-1:0] ev1, logic [DW-1:0] ev2, int efree);
    vec_t r;
    r.dv = dv; r.pay = pay; r.dst = dst; r.t1 = t1; r.r1 = r1; r.v1 = v1;
    r.t2 = t2; r.r2 = r2; r.v2 = v2; r.cv = cv; r.lane = lane; r.ct = ct; r.cd = cd;
    r.irdy = irdy; r.ev = ev; r.edst = edst; r.ev1 = ev1; r.ev2 = ev2; r.efree = efree;
    return r;
  endfunction

  vec_t tv [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int avail;
    tv[0]  = mk(1, 16'hA1, 1, 5, 1, 32'h11, 6, 1, 32'h22, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h11, 32'h22, 7);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8);
    tv[3]  = mk(1, 16'hA3, 7, 4, 1, 32'h44, 3, 0, 0, 1, 0, 3, 32'h7, 1, 0, 0, 0, 0, 8);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 32'h44, 32'h7, 7);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8);
    tv[6]  = mk(1, 16'hA6, 8, 9, 0, 0, 2, 1, 32'h55, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7);
    tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7);
`ifdef RS_WAKE_ISSUE_EN
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 32'hDEAD, 1, 1, 8, 32'hDEAD, 32'h55, 7);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8);
`else
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 32'hDEAD, 1, 0, 0, 0, 0, 7);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8, 32'hDEAD, 32'h55, 7);
`endif
    tv[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8);

    reset = 0;
    idle();
    model_reset();
    #12;
    chk("reset_iss_valid", 64'(iss_valid), 0);
    chk("reset_free", 64'(free_slots), 8);
    chk("reset_payload", 64'(iss_payload), 0);
    chk("reset_src1", 64'(iss_src1_val), 0);
    chk("reset_src2", 64'(iss_src2_val), 0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 12; i++) begin
      idle();
      if (tv[i].dv)
        set_slot(0, tv[i].pay, tv[i].dst, tv[i].t1, tv[i].r1, tv[i].v1,
                 tv[i].t2, tv[i].r2, tv[i].v2);
      if (tv[i].cv) set_lane(tv[i].lane, tv[i].ct, tv[i].cd);
      iss_ready = tv[i].irdy;
      pre();
      chk($sformatf("tv%0d_valid", i), 64'(iss_valid), 64'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_dst", i), 64'(iss_dest_tag), 64'(tv[i].edst));
        chk($sformatf("tv%0d_src1", i), 64'(iss_src1_val), 64'(tv[i].ev1));
        chk($sformatf("tv%0d_src2", i), 64'(iss_src2_val), 64'(tv[i].ev2));
      end
      chk($sformatf("tv%0d_free", i), 64'(free_slots), 64'(tv[i].efree));
      advance();
    end

    for (int c = 0; c < 4; c++) begin
      idle();
      for (int s = 0; s < 2; s++)
        set_slot(s, PW'(16'h100 + 2*c + s), TW'(40 + 2*c + s), TW'(20 + 2*c + s),
                 0, 0, 0, 1, DW'(2*c + s));
      cyc();
    end
    idle();
    pre();
    chk("full_free", 64'(free_slots), 0);
    chk("full_no_issue", 64'(iss_valid), 0);
    advance();
    idle();
    set_lane(0, 26, 32'h600);
    set_lane(1, 22, 32'h200);
    cyc();
    idle(); iss_ready = 1;
    pre();
    chk("order_first_dst", 64'(iss_dest_tag), 42);
    chk("order_first_src1", 64'(iss_src1_val), 32'h200);
    advance();
    idle(); iss_ready = 1;
    pre();
    chk("order_second_dst", 64'(iss_dest_tag), 46);
    chk("order_second_src1", 64'(iss_src1_val), 32'h600);
    chk("order_second_free", 64'(free_slots), 1);
    advance();
    idle(); iss_ready = 1;
    pre();
    chk("order_drained", 64'(iss_valid), 0);
    chk("order_free", 64'(free_slots), 2);
    advance();

    idle();
    set_slot(0, 16'h200, 60, 1, 1, 1, 2, 1, 2);
    set_slot(1, 16'h201, 61, 3, 1, 3, 4, 1, 4);
    set_lane(0, 20, 32'h5);
    flush = 1; iss_ready = 1;
    cyc();
    idle();
    pre();
    chk("flush_free", 64'(free_slots), 8);
    chk("flush_no_issue", 64'(iss_valid), 0);
    advance();

    for (int c = 0; c < 2; c++) begin
      idle();
      set_slot(0, PW'(16'h280 + 2*c), TW'(10 + 2*c), 1, 1, 1, 2, 1, 2);
      set_slot(1, PW'(16'h281 + 2*c), TW'(11 + 2*c), 1, 1, 1, 2, 1, 2);
      cyc();
    end
    idle();
    #3;
    reset = 0;
    #1;
    chk("arst_iss_valid", 64'(iss_valid), 0);
    chk("arst_free", 64'(free_slots), 8);
    chk("arst_dst", 64'(iss_dest_tag), 0);
    chk("arst_payload", 64'(iss_payload), 0);
    chk("arst_src1", 64'(iss_src1_val), 0);
    model_reset();
    #2;
    reset = 1;
    @(posedge clock);
    #1;
    idle();
    set_slot(0, 16'h300, 50, 33, 0, 0, 34, 1, 32'h34);
    set_slot(1, 16'h301, 51, 35, 1, 32'h35, 36, 1, 32'h36);
    cyc();
    idle();
    pre();
    chk("resume_ready_dst", 64'(iss_dest_tag), 51);
    advance();
    idle();
    set_lane(0, 33, 32'h333);
    cyc();
    idle();
    pre();
    chk("resume_entry0_dst", 64'(iss_dest_tag), 50);
    chk("resume_entry0_src1", 64'(iss_src1_val), 32'h333);
    advance();
    idle(); flush = 1;
    cyc();

    for (int i = 0; i < 3000; i++) begin
      idle();
      flush = ($urandom_range(0, 63) == 0);
      avail = m_free;
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 1) == 1 && avail > 0) begin
          avail--;
          set_slot(s, PW'($urandom), TW'($urandom_range(0, 63)),
                   TW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                   TW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
        end
      for (int l = 0; l < N; l++)
        if ($urandom_range(0, 9) < 4) set_lane(l, TW'($urandom_range(0, 15)), $urandom);
      if (cdb_valid[0] && cdb_valid[1] && cdb_tag[0 +: TW] == cdb_tag[TW +: TW])
        cdb_valid[1] = 0;
      iss_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
